chnl_slave_fifo: RTL and testbench
==================================

CHNL_SLAVE_FIFO -- requirements
Module: chnl_slave_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, data width of channel words.
REQ-002 SHALL have parameter DEPTH, default 32, FIFO entries; power of two, 2..32.
REQ-003 SHALL have parameter MW, default 6, margin width; must satisfy 2^MW > DEPTH.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset: asynchronous, active-high.
REQ-006 SHALL have port en_i  input  1  channel enable; gates acceptance of writes.
REQ-007 SHALL have port flush_i  input  1  synchronous FIFO clear.
REQ-008 SHALL have port ch_data_i  input  DW  write data from channel initiator.
REQ-009 SHALL have port ch_valid_i  input  1  initiator offers ch_data_i.
REQ-010 SHALL have port ch_ready_o  output  1  block can accept a word this cycle.
REQ-011 SHALL have port ch_margin_o  output  MW  free entries (DEPTH minus occupancy).
REQ-012 SHALL have port fifo_req_o  output  1  FIFO non-empty; word available to arbiter.
REQ-013 SHALL have port fifo_data_o  output  DW  head-of-FIFO word (show-ahead).
REQ-014 SHALL have port fifo_pop_i  input  1  arbiter grant; consumes head word.
REQ-015 SHALL have port pop_err_o  output  1  sticky flag: pop attempted while empty.

Function
REQ-016 SHALL track occupancy cnt (0..DEPTH), write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL drive ch_ready_o = en_i AND (cnt < DEPTH), combinationally from registered cnt.
REQ-018 SHALL accept (push) a word on a rising edge where ch_valid_i=1 and ch_ready_o=1: store at wp, wp+1.
REQ-019 SHALL hold ch_valid_i=1 with ch_ready_o=0 as a stall: no write, no data loss accounting, no flag.
REQ-020 SHALL drive ch_margin_o = DEPTH - cnt, zero-extended to MW bits; DEPTH (e.g. 32) when empty, 0 when full.
REQ-021 SHALL drive fifo_req_o = (cnt != 0) and fifo_data_o = mem[rp]; fifo_data_o don't-care when empty.
REQ-022 SHALL pop on a rising edge where fifo_pop_i=1 and cnt != 0: rp+1.
REQ-023 SHALL, on fifo_pop_i=1 with cnt=0, ignore the pop and set pop_err_o=1 next cycle, held until reset or flush.
REQ-024 SHALL, on simultaneous push and pop with 0<cnt<DEPTH, update both pointers and leave cnt unchanged.
REQ-025 SHALL, with cnt=DEPTH, refuse a push even if a pop occurs in the same cycle (no same-cycle pass-through); ready rises the cycle after the pop.
REQ-026 SHALL, with cnt=0, accept a push while ignoring a simultaneous pop (pop_err_o set); the word appears on fifo_data_o one cycle after the push (no bypass).
REQ-027 SHALL have push-to-fifo_req_o latency of exactly 1 cycle.
REQ-028 SHALL, on flush_i=1 at a rising edge, set cnt=0, wp=0, rp=0, pop_err_o=0, discarding any same-cycle push and pop; flush has priority.
REQ-029 SHALL, when en_i is deasserted, keep stored data and keep serving pops; only writes stop.
REQ-030 SHALL preserve word order: words leave in exactly the order accepted.

Reset
REQ-031 SHALL, while rstn=1, asynchronously force cnt=0, wp=0, rp=0, pop_err_o=0.
REQ-032 SHALL therefore present during reset: ch_ready_o=en_i, ch_margin_o=DEPTH, fifo_req_o=0.
REQ-033 SHALL, on reset mid-transfer, drop all stored words; memory contents need not be cleared.
REQ-034 SHALL resume normal operation on the first rising edge after rstn falls to 0.

Verification
REQ-035 Reset then en_i=1, push 0x00C00000..0x00C00004 back-to-back, no pops -> ch_margin_o steps 32,31,...,27; fifo_req_o=1 from cycle after first push.
REQ-036 Push 32 words 0x00C10000+i with no pops -> ch_ready_o=0, ch_margin_o=0; 33rd word held with ch_valid_i=1 until one pop, then accepted the following cycle.
REQ-037 Continuous push and pop at cnt=5 for 100 cycles -> cnt stays 5, margin 27, popped sequence equals pushed sequence 0x00C20000+i.
REQ-038 fifo_pop_i=1 on empty FIFO -> no pointer change, pop_err_o=1 next cycle and stays 1; flush_i pulse -> pop_err_o=0.
REQ-039 Fill 10 words, assert rstn=1 mid-burst -> immediately fifo_req_o=0, ch_margin_o=32; after release, first push 0xDEADBEEF is first word popped.
REQ-040 en_i=0 with 3 words stored and ch_valid_i=1 -> ch_ready_o=0, no push; 3 pops return stored words in order, margin returns to 32.

Source files
------------

// File: rtl/chnl_slave_fifo.sv
// chnl_slave_fifo: channel-side receive FIFO.
// Words offered on the channel (valid/ready) are stored in a show-ahead FIFO
// and presented to a downstream arbiter as a request with the head word.
// The arbiter consumes words with fifo_pop_i. A pop on an empty FIFO is
// ignored and recorded in a sticky error flag until reset or flush.
// A full FIFO refuses writes even when a pop happens in the same cycle, and
// an empty FIFO never forwards a word in the cycle it is written.
module chnl_slave_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int MW    = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic [DW-1:0] ch_data_i,
    input  logic          ch_valid_i,
    output logic          ch_ready_o,
    output logic [MW-1:0] ch_margin_o,
    output logic          fifo_req_o,
    output logic [DW-1:0] fifo_data_o,
    input  logic          fifo_pop_i,
    output logic          pop_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [MW-1:0] r_cnt;
    logic          r_pop_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pop_empty;

    // Occupancy status. Ready is derived from the registered count only, so
    // a pop in the same cycle can never open a slot in a full FIFO.
    assign w_full      = (r_cnt == MW'(DEPTH));
    assign w_empty     = (r_cnt == '0);
    assign ch_ready_o  = en_i & ~w_full;
    assign w_push      = ch_valid_i & ch_ready_o & ~flush_i;
    assign w_pop       = fifo_pop_i & ~w_empty & ~flush_i;
    assign w_pop_empty = fifo_pop_i & w_empty;

    assign ch_margin_o = MW'(DEPTH) - r_cnt;
    assign fifo_req_o  = ~w_empty;
    assign fifo_data_o = r_mem[r_rp];
    assign pop_err_o   = r_pop_err;

    // Storage array; not reset, stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= ch_data_i;
        end
    end

    // Pointers, occupancy and sticky pop error; flush overrides any
    // same-cycle push or pop.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_pop_err <= 1'b0;
        end else if (flush_i) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_pop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + MW'(1);
                2'b01:   r_cnt <= r_cnt - MW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_pop_empty) begin
                r_pop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chnl_slave_fifo.sv
// tb_chnl_slave_fifo: directed bench for chnl_slave_fifo with expected
// values written out by hand.
module tb_chnl_slave_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int MW    = 6;

    logic          clk;
    logic          rstn;
    logic          en_i;
    logic          flush_i;
    logic [DW-1:0] ch_data_i;
    logic          ch_valid_i;
    logic          ch_ready_o;
    logic [MW-1:0] ch_margin_o;
    logic          fifo_req_o;
    logic [DW-1:0] fifo_data_o;
    logic          fifo_pop_i;
    logic          pop_err_o;

    int n_chk;
    int n_err;

    chnl_slave_fifo #(.DW(DW), .DEPTH(DEPTH), .MW(MW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en_i        (en_i),
        .flush_i     (flush_i),
        .ch_data_i   (ch_data_i),
        .ch_valid_i  (ch_valid_i),
        .ch_ready_o  (ch_ready_o),
        .ch_margin_o (ch_margin_o),
        .fifo_req_o  (fifo_req_o),
        .fifo_data_o (fifo_data_o),
        .fifo_pop_i  (fifo_pop_i),
        .pop_err_o   (pop_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rstn       = 1'b1;
        en_i       = 1'b1;
        flush_i    = 1'b0;
        ch_data_i  = '0;
        ch_valid_i = 1'b0;
        fifo_pop_i = 1'b0;

        // Held in reset.
        #3;
        chk("rst_ready", ch_ready_o, 1);
        chk("rst_margin", ch_margin_o, 32);
        chk("rst_req", fifo_req_o, 0);
        chk("rst_poperr", pop_err_o, 0);
        tick();
        rstn = 1'b0;
        tick();

        // Back-to-back pushes, margin steps down.
        chk("b2b_margin0", ch_margin_o, 32);
        for (int i = 0; i < 5; i++) begin
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C0_0000 + 32'(i);
            tick();
            chk("b2b_margin", ch_margin_o, 64'(31 - i));
            chk("b2b_req", fifo_req_o, 1);
        end
        ch_valid_i = 1'b0;
        chk("b2b_head", fifo_data_o, 32'h00C0_0000);
        do_flush();
        chk("flush_margin", ch_margin_o, 32);
        chk("flush_req", fifo_req_o, 0);

        // Fill to full, stall the 33rd word, release with one pop.
        for (int i = 0; i < 32; i++) begin
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C1_0000 + 32'(i);
            tick();
        end
        chk("full_ready", ch_ready_o, 0);
        chk("full_margin", ch_margin_o, 0);
        ch_data_i = 32'h00C1_0020;
        tick();
        chk("stall_margin", ch_margin_o, 0);
        chk("stall_ready", ch_ready_o, 0);
        fifo_pop_i = 1'b1;
        tick();
        fifo_pop_i = 1'b0;
        chk("pop_full_margin", ch_margin_o, 1);
        chk("pop_full_ready", ch_ready_o, 1);
        chk("pop_full_head", fifo_data_o, 32'h00C1_0001);
        tick();
        ch_valid_i = 1'b0;
        chk("w33_margin", ch_margin_o, 0);
        for (int i = 1; i <= 32; i++) begin
            chk("full_order", fifo_data_o, 32'h00C1_0000 + 32'(i));
            fifo_pop_i = 1'b1;
            tick();
        end
        fifo_pop_i = 1'b0;
        chk("drain_margin", ch_margin_o, 32);
        chk("drain_req", fifo_req_o, 0);
        chk("drain_poperr", pop_err_o, 0);

        // Steady push+pop at occupancy 5.
        for (int i = 0; i < 5; i++) begin
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C2_0000 + 32'(i);
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            chk("steady_margin", ch_margin_o, 27);
            chk("steady_data", fifo_data_o, 32'h00C2_0000 + 32'(i));
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C2_0000 + 32'(i + 5);
            fifo_pop_i = 1'b1;
            tick();
        end
        ch_valid_i = 1'b0;
        chk("steady_end_margin", ch_margin_o, 27);
        for (int i = 100; i < 105; i++) begin
            chk("steady_tail", fifo_data_o, 32'h00C2_0000 + 32'(i));
            fifo_pop_i = 1'b1;
            tick();
        end
        fifo_pop_i = 1'b0;
        chk("steady_empty", ch_margin_o, 32);
        chk("steady_poperr", pop_err_o, 0);

        // Pop on empty sets a sticky error.
        fifo_pop_i = 1'b1;
        tick();
        fifo_pop_i = 1'b0;
        chk("perr_set", pop_err_o, 1);
        chk("perr_margin", ch_margin_o, 32);
        chk("perr_req", fifo_req_o, 0);
        tick();
        tick();
        chk("perr_sticky", pop_err_o, 1);
        ch_valid_i = 1'b1;
        ch_data_i  = 32'h0000_00A5;
        tick();
        ch_valid_i = 1'b0;
        chk("perr_head", fifo_data_o, 32'h0000_00A5);
        chk("perr_req1", fifo_req_o, 1);
        fifo_pop_i = 1'b1;
        tick();
        fifo_pop_i = 1'b0;
        chk("perr_req0", fifo_req_o, 0);
        do_flush();
        chk("perr_clear", pop_err_o, 0);

        // Push with simultaneous pop on empty: push kept, pop flagged, no bypass.
        ch_valid_i = 1'b1;
        ch_data_i  = 32'h0000_1234;
        fifo_pop_i = 1'b1;
        #1;
        chk("nobypass_req", fifo_req_o, 0);
        tick();
        ch_valid_i = 1'b0;
        fifo_pop_i = 1'b0;
        chk("empty_pp_req", fifo_req_o, 1);
        chk("empty_pp_data", fifo_data_o, 32'h0000_1234);
        chk("empty_pp_err", pop_err_o, 1);
        chk("empty_pp_margin", ch_margin_o, 31);

        // Flush beats a same-cycle push.
        flush_i    = 1'b1;
        ch_valid_i = 1'b1;
        ch_data_i  = 32'h0000_5555;
        tick();
        flush_i    = 1'b0;
        ch_valid_i = 1'b0;
        chk("flushpri_margin", ch_margin_o, 32);
        chk("flushpri_req", fifo_req_o, 0);
        chk("flushpri_err", pop_err_o, 0);

        // Reset mid-burst.
        for (int i = 0; i < 10; i++) begin
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C4_0000 + 32'(i);
            tick();
        end
        chk("pre_rst_margin", ch_margin_o, 22);
        rstn = 1'b1;
        #1;
        chk("midrst_req", fifo_req_o, 0);
        chk("midrst_margin", ch_margin_o, 32);
        ch_valid_i = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        ch_valid_i = 1'b1;
        ch_data_i  = 32'hDEAD_BEEF;
        tick();
        ch_valid_i = 1'b0;
        chk("postrst_data", fifo_data_o, 32'hDEAD_BEEF);
        chk("postrst_margin", ch_margin_o, 31);
        fifo_pop_i = 1'b1;
        tick();
        fifo_pop_i = 1'b0;
        chk("postrst_req", fifo_req_o, 0);

        // Disabled channel still drains.
        for (int i = 0; i < 3; i++) begin
            ch_valid_i = 1'b1;
            ch_data_i  = 32'h00C5_0000 + 32'(i);
            tick();
        end
        en_i      = 1'b0;
        ch_data_i = 32'h0BAD_0BAD;
        #1;
        chk("dis_ready", ch_ready_o, 0);
        tick();
        chk("dis_margin", ch_margin_o, 29);
        for (int i = 0; i < 3; i++) begin
            chk("dis_order", fifo_data_o, 32'h00C5_0000 + 32'(i));
            fifo_pop_i = 1'b1;
            tick();
        end
        fifo_pop_i = 1'b0;
        ch_valid_i = 1'b0;
        chk("dis_margin_end", ch_margin_o, 32);
        chk("dis_req_end", fifo_req_o, 0);
        en_i = 1'b1;
        #1;
        chk("en_ready", ch_ready_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
